fsm_periferico: RTL and testbench

Peripheral-side receiver for the CPU→peripheral link. It completes the four-phase send/ack handshake driven by the CPU block. It synchronizes `send` into its own clock domain and captures each 3-bit word into a small FIFO. Buffered words are presented downstream on a valid/ready port. When the FIFO is full, it applies backpressure by withholding `ack`.

---
 rtl/fsm_periferico.sv | 56 +++++
 tb/tb_fsm_periferico.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/fsm_periferico.sv
// fsm_periferico: peripheral-side send/ack receiver that buffers CPU words in a FIFO with valid/ready output
module fsm_periferico #(
  parameter int DW = 3,
  parameter int DEPTH = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk1,
  input  logic                     rst1,
  input  logic                     send,
  input  logic [DW-1:0]            data,
  output logic                     ack,
  output logic [DW-1:0]            dout,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [7:0]               count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  typedef enum logic {IDLE, ACK} state_t;
  state_t state, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [DW-1:0] mem [DEPTH];
  logic send_s, push, pop;
  assign send_s = sync_q[SYNC_STAGES-1];
  assign ack = (state == ACK);
  assign dout_valid = (level != '0);
  assign dout = dout_valid ? mem[rd_ptr] : '0;
  // a full FIFO refuses the push even if it pops this cycle; the held send retries next cycle
  always_comb begin
    push = (state == IDLE) && send_s && (level != FULL);
    pop = dout_valid && dout_ready;
    state_d = (state == IDLE) ? (push ? ACK : IDLE) : (send_s ? ACK : IDLE);
  end
  always_ff @(posedge clk1 or negedge rst1) begin
    if (!rst1) begin
      sync_q <= '0;
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      count <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], send};
      state <= state_d;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push != pop) level <= push ? level + 1'b1 : level - 1'b1;
      if (push) count <= count + 1'b1;
    end
  end
  always_ff @(posedge clk1) begin
    if (push) mem[wr_ptr] <= data;
  end
endmodule

// File: tb/tb_fsm_periferico.sv
// tb_fsm_periferico: directed handshakes with a queue scoreboard checking every word popped from the FIFO
module tb_fsm_periferico;
  logic clk1 = 0, rst1 = 0, send = 0, dout_ready = 0, ack, dout_valid;
  logic [2:0] data = 0, dout;
  logic [2:0] level;
  logic [7:0] count;
  logic [2:0] exp_q [$];
  int n_cmp = 0, n_bad = 0;

  fsm_periferico dut (.clk1(clk1), .rst1(rst1), .send(send), .data(data), .ack(ack),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .level(level), .count(count));

  always #5 clk1 = ~clk1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // the edge that acts on dout_ready sees the same values sampled here
  always @(negedge clk1) begin
    if (rst1 && dout_valid && dout_ready) begin
      if (exp_q.size() == 0) check("unexpected_pop", int'(dout), -1);
      else check("pop_data", int'(dout), int'(exp_q.pop_front()));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk1);
    #1;
  endtask

  task automatic wait_ack(input logic v);
    int n = 0;
    while (ack !== v && n < 50) begin tick(1); n++; end
    if (n == 50) check("ack_timeout", int'(ack), int'(v));
  endtask

  task automatic handshake(input logic [2:0] d);
    data = d;
    send = 1;
    exp_q.push_back(d);
    wait_ack(1);
    send = 0;
    wait_ack(0);
  endtask

  task automatic drain();
    int n = 0;
    dout_ready = 1;
    while (dout_valid && n < 50) begin tick(1); n++; end
    if (n == 50) check("drain_timeout", int'(dout_valid), 0);
    dout_ready = 0;
  endtask

  task automatic do_reset();
    rst1 = 0;
    exp_q.delete();
    tick(2);
    rst1 = 1;
    tick(1);
  endtask

  initial begin
    do_reset();
    check("rst_ack", int'(ack), 0);
    check("rst_valid", int'(dout_valid), 0);
    check("rst_level", int'(level), 0);
    check("rst_count", int'(count), 0);
    check("rst_dout", int'(dout), 0);
    // single transfer with exact ack latency
    data = 5; send = 1; exp_q.push_back(3'd5);
    tick(2);
    check("ack_early", int'(ack), 0);
    tick(1);
    check("ack_rise", int'(ack), 1);
    check("single_dout", int'(dout), 5);
    check("single_valid", int'(dout_valid), 1);
    check("single_level", int'(level), 1);
    check("single_count", int'(count), 1);
    send = 0;
    tick(2);
    check("ack_hold", int'(ack), 1);
    tick(1);
    check("ack_fall", int'(ack), 0);
    drain();
    // burst into a full FIFO, then backpressure
    for (int i = 1; i <= 4; i++) handshake(3'(i));
    check("burst_level", int'(level), 4);
    data = 6; send = 1; exp_q.push_back(3'd6);
    tick(8);
    check("full_no_ack", int'(ack), 0);
    check("full_level", int'(level), 4);
    dout_ready = 1;
    tick(1);
    dout_ready = 0;
    check("after_pop_level", int'(level), 3);
    wait_ack(1);
    check("refill_level", int'(level), 4);
    send = 0;
    wait_ack(0);
    drain();
    // simultaneous push and pop at level 2
    handshake(3'd7);
    handshake(3'd0);
    check("pp_level_pre", int'(level), 2);
    data = 3; send = 1; exp_q.push_back(3'd3);
    tick(2);
    dout_ready = 1;
    tick(1);
    dout_ready = 0;
    check("pp_ack", int'(ack), 1);
    check("pp_level", int'(level), 2);
    send = 0;
    wait_ack(0);
    drain();
    // pointer wrap and count wrap
    do_reset();
    dout_ready = 1;
    for (int i = 0; i < 10; i++) handshake(3'(i * 3 + 1));
    tick(2);
    check("wrap_count10", int'(count), 10);
    check("wrap_level", int'(level), 0);
    for (int i = 10; i < 256; i++) handshake(3'(i));
    tick(2);
    check("wrap_count256", int'(count), 0);
    dout_ready = 0;
    // reset mid-handshake with send still high
    do_reset();
    handshake(3'd1);
    handshake(3'd2);
    data = 4; send = 1;
    wait_ack(1);
    check("mid_level", int'(level), 3);
    rst1 = 0;
    #2;
    check("mid_rst_ack", int'(ack), 0);
    check("mid_rst_valid", int'(dout_valid), 0);
    check("mid_rst_level", int'(level), 0);
    check("mid_rst_count", int'(count), 0);
    exp_q.delete();
    tick(2);
    exp_q.push_back(3'd4);
    rst1 = 1;
    wait_ack(1);
    check("recap_count", int'(count), 1);
    check("recap_dout", int'(dout), 4);
    send = 0;
    wait_ack(0);
    drain();
    // held send: one push only
    data = 2; send = 1; exp_q.push_back(3'd2);
    wait_ack(1);
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check("held_ack", int'(ack), 1);
    end
    check("held_level", int'(level), 1);
    check("held_count", int'(count), 2);
    send = 0;
    wait_ack(0);
    drain();
    tick(2);
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
